memory_stage: RTL

- MEM stage of the 5-stage RV32 pipeline. Consumes the EX/MEM register outputs of the execute stage and performs data-memory access.
- Word-organised data RAM with byte and halfword lanes; loads are sign- or zero-extended.
- Owns the MEM/WB pipeline register and the write-back result mux.
- Returns the two forwarding values the execute stage consumes: the MEM-stage ALU value and the WB-stage result.

---
 rtl/memory_stage.sv | 135 +++++++++++++
 1 files changed

// File: rtl/memory_stage.sv
// MEM stage of the RV32 pipeline: byte-lane data RAM, load extraction,
// MEM/WB pipeline register and the write-back result mux.
module memory_stage #(
   parameter int DEPTH_WORDS = 256,
   parameter int AW          = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        regwritem,
   input  logic [1:0]  resultsrcm,
   input  logic        memwritem,
   input  logic [2:0]  funct3m,
   input  logic [31:0] solm,
   input  logic [31:0] regdatam,
   input  logic [4:0]  rdm,
   input  logic [4:0]  nxtaddoutm,
   output logic [31:0] memregvalue,
   output logic        regwritew,
   output logic [4:0]  rdw,
   output logic [31:0] resultw,
   output logic        misalignw
);

   // funct3m[1:0]: 00 byte, 01 halfword, anything else word; funct3m[2] selects zero-extension
   function automatic logic [31:0] load_extract(input logic [31:0] word,
                                                input logic [1:0]  lane,
                                                input logic [2:0]  f3);
      logic signed [7:0]  b;
      logic signed [15:0] h;
      case (lane)
         2'd0:    b = word[7:0];
         2'd1:    b = word[15:8];
         2'd2:    b = word[23:16];
         default: b = word[31:24];
      endcase
      h = lane[1] ? word[31:16] : word[15:0];
      case (f3[1:0])
         2'b00:   return f3[2] ? {24'b0, b} : 32'(b);
         2'b01:   return f3[2] ? {16'b0, h} : 32'(h);
         default: return word;
      endcase
   endfunction

   logic [31:0]   mem_q [DEPTH_WORDS];
   logic [AW-1:0] idx;
   logic [31:0]   rd_word;
   logic [31:0]   wdata;
   logic [3:0]    be;
   logic          misaligned;
   logic          is_load;

   logic          regwrite_q,  regwrite_d;
   logic [4:0]    rd_q,        rd_d;
   logic [1:0]    resultsrc_q, resultsrc_d;
   logic [31:0]   alu_q,       alu_d;
   logic [31:0]   load_q,      load_d;
   logic [31:0]   pc4_q,       pc4_d;
   logic          misalign_q,  misalign_d;

   assign idx         = solm[AW+1:2];
   assign rd_word     = mem_q[idx];
   assign is_load     = (resultsrcm == 2'b01);
   assign memregvalue = solm;

   always_comb begin
      misaligned = 1'b0;
      be         = 4'b1111;
      wdata      = regdatam;
      case (funct3m[1:0])
         2'b00: begin
            be    = 4'b0001 << solm[1:0];
            wdata = {4{regdatam[7:0]}};
         end
         2'b01: begin
            misaligned = solm[0];
            be         = solm[1] ? 4'b1100 : 4'b0011;
            wdata      = {2{regdatam[15:0]}};
         end
         default: misaligned = (solm[1:0] != 2'b00);
      endcase
   end

   // Stores land on the edge; the read path is asynchronous so a following load sees them
   always_ff @(posedge clk) begin
      if (reset && memwritem && !misaligned) begin
         for (int i = 0; i < 4; i++) begin
            if (be[i]) mem_q[idx][i*8 +: 8] <= wdata[i*8 +: 8];
         end
      end
   end

   always_comb begin
      regwrite_d  = regwritem && !(is_load && misaligned);
      rd_d        = rdm;
      resultsrc_d = resultsrcm;
      alu_d       = solm;
      load_d      = misaligned ? 32'b0 : load_extract(rd_word, solm[1:0], funct3m);
      pc4_d       = {27'b0, nxtaddoutm};
      misalign_d  = (memwritem || is_load) && misaligned;
   end

   // MEM/WB boundary
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         regwrite_q  <= 1'b0;
         rd_q        <= 5'b0;
         resultsrc_q <= 2'b0;
         alu_q       <= 32'b0;
         load_q      <= 32'b0;
         pc4_q       <= 32'b0;
         misalign_q  <= 1'b0;
      end else begin
         regwrite_q  <= regwrite_d;
         rd_q        <= rd_d;
         resultsrc_q <= resultsrc_d;
         alu_q       <= alu_d;
         load_q      <= load_d;
         pc4_q       <= pc4_d;
         misalign_q  <= misalign_d;
      end
   end

   assign regwritew = regwrite_q;
   assign rdw       = rd_q;
   assign misalignw = misalign_q;

   always_comb begin
      case (resultsrc_q)
         2'b01:   resultw = load_q;
         2'b10:   resultw = pc4_q;
         default: resultw = alu_q;
      endcase
   end

endmodule
